// File: rtl/mode_sel_mux.sv
// Frame-synchronous source selector: keyboard next/prev steps pick a mode, committed at frame_start.
// Optional post-switch shoot/red_detect masking enabled by macro MUX_SHOOT_HOLDOFF_EN.
module mode_sel_mux #(
   parameter int NUM_MODES      = 2,
   parameter int INIT_MODE      = 0,
   parameter int KEY_NEXT_BIT   = 5,
   parameter int KEY_PREV_BIT   = 6,
   parameter int HOLDOFF_FRAMES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              keyboard_data,
   input  logic                    frame_start,
   input  logic [NUM_MODES-1:0]    target_off_in,
   input  logic [4*NUM_MODES-1:0]  r_port_in,
   input  logic [4*NUM_MODES-1:0]  g_port_in,
   input  logic [4*NUM_MODES-1:0]  b_port_in,
   input  logic [10*NUM_MODES-1:0] x_coor_in,
   input  logic [10*NUM_MODES-1:0] y_coor_in,
   input  logic [NUM_MODES-1:0]    red_detect_in,
   input  logic [NUM_MODES-1:0]    shoot_in,
   output logic                    target_off,
   output logic                    red_detect,
   output logic                    shoot,
   output logic [3:0]              r_port,
   output logic [3:0]              g_port,
   output logic [3:0]              b_port,
   output logic [9:0]              x_coor,
   output logic [9:0]              y_coor,
   output logic [2:0]              mode,
   output logic                    switch_pending,
   output logic                    holdoff_active
);

   localparam logic [2:0] LAST_MODE = 3'(NUM_MODES - 1);
   localparam logic [2:0] RST_MODE  = 3'(INIT_MODE);

   logic       next_q, prev_q;
   logic       next_rise, prev_rise;
   logic       step_next, step_prev;
   logic [2:0] mode_q, target_q;
   logic [2:0] mode_nxt, target_nxt;
   logic       commit_change;
   logic       shoot_sel, red_sel;

   assign next_rise = keyboard_data[KEY_NEXT_BIT] & ~next_q;
   assign prev_rise = keyboard_data[KEY_PREV_BIT] & ~prev_q;
   // Simultaneous rising edges cancel each other
   assign step_next = next_rise & ~prev_rise;
   assign step_prev = prev_rise & ~next_rise;

   always_comb begin
      target_nxt = target_q;
      if (step_next)
         target_nxt = (target_q == LAST_MODE) ? 3'd0 : target_q + 3'd1;
      else if (step_prev)
         target_nxt = (target_q == 3'd0) ? LAST_MODE : target_q - 3'd1;
   end

   // Commit takes the pre-step target; a coincident step lands in target for the next frame
   assign mode_nxt      = frame_start ? target_q : mode_q;
   assign commit_change = frame_start && (target_q != mode_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         next_q   <= 1'b0;
         prev_q   <= 1'b0;
         mode_q   <= RST_MODE;
         target_q <= RST_MODE;
      end else begin
         next_q   <= keyboard_data[KEY_NEXT_BIT];
         prev_q   <= keyboard_data[KEY_PREV_BIT];
         mode_q   <= mode_nxt;
         target_q <= target_nxt;
      end
   end

   assign mode           = mode_q;
   assign switch_pending = (target_q != mode_q);

`ifdef MUX_SHOOT_HOLDOFF_EN
   logic [3:0] holdoff_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         holdoff_cnt <= 4'd0;
      else if (commit_change)
         holdoff_cnt <= 4'(HOLDOFF_FRAMES);
      else if (frame_start && (holdoff_cnt != 4'd0))
         holdoff_cnt <= holdoff_cnt - 4'd1;
   end

   assign holdoff_active = (holdoff_cnt != 4'd0);
`else
   logic unused_holdoff;
   assign unused_holdoff = commit_change ^ (|4'(HOLDOFF_FRAMES));
   assign holdoff_active = 1'b0;
`endif

   always_comb begin
      target_off = 1'b0;
      red_sel    = 1'b0;
      shoot_sel  = 1'b0;
      r_port     = 4'd0;
      g_port     = 4'd0;
      b_port     = 4'd0;
      x_coor     = 10'd0;
      y_coor     = 10'd0;
      for (int i = 0; i < NUM_MODES; i++) begin
         if (mode_q == 3'(i)) begin
            target_off = target_off_in[i];
            red_sel    = red_detect_in[i];
            shoot_sel  = shoot_in[i];
            r_port     = r_port_in[4*i +: 4];
            g_port     = g_port_in[4*i +: 4];
            b_port     = b_port_in[4*i +: 4];
            x_coor     = x_coor_in[10*i +: 10];
            y_coor     = y_coor_in[10*i +: 10];
         end
      end
   end

   assign shoot      = shoot_sel & ~holdoff_active;
   assign red_detect = red_sel & ~holdoff_active;

   logic unused_keys;
   assign unused_keys = ^keyboard_data;

endmodule

// File: tb/tb_mode_sel_mux.sv
// Directed bench for mode_sel_mux with NUM_MODES=3; holdoff expectations follow MUX_SHOOT_HOLDOFF_EN.
module tb_mode_sel_mux;

`ifdef MUX_SHOOT_HOLDOFF_EN
   localparam int HO = 1;
`else
   localparam int HO = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  kd;
   logic        fs;
   logic [2:0]  target_off_in = 3'b010;
   logic [11:0] r_in = {4'hC, 4'hB, 4'hA};
   logic [11:0] g_in = {4'h3, 4'h2, 4'h1};
   logic [11:0] b_in = {4'h6, 4'h5, 4'h4};
   logic [29:0] x_in = {10'd300, 10'd200, 10'd100};
   logic [29:0] y_in = {10'd30, 10'd20, 10'd10};
   logic [2:0]  red_in = 3'b111;
   logic [2:0]  shoot_in = 3'b111;
   logic        target_off, red_detect, shoot, switch_pending, holdoff_active;
   logic [3:0]  r_port, g_port, b_port;
   logic [9:0]  x_coor, y_coor;
   logic [2:0]  mode;

   int n_checks = 0;
   int n_errors = 0;

   mode_sel_mux #(.NUM_MODES(3), .INIT_MODE(0), .KEY_NEXT_BIT(5), .KEY_PREV_BIT(6),
                  .HOLDOFF_FRAMES(2)) dut (
      .clk(clk), .reset(reset), .keyboard_data(kd), .frame_start(fs),
      .target_off_in(target_off_in), .r_port_in(r_in), .g_port_in(g_in), .b_port_in(b_in),
      .x_coor_in(x_in), .y_coor_in(y_in), .red_detect_in(red_in), .shoot_in(shoot_in),
      .target_off(target_off), .red_detect(red_detect), .shoot(shoot),
      .r_port(r_port), .g_port(g_port), .b_port(b_port), .x_coor(x_coor), .y_coor(y_coor),
      .mode(mode), .switch_pending(switch_pending), .holdoff_active(holdoff_active)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int idx);
      kd = 8'h00;
      kd[idx] = 1'b1;
      tick();
      kd = 8'h00;
      tick();
   endtask

   task automatic frame();
      fs = 1'b1;
      tick();
      fs = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      kd = 8'h00;
      fs = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      check_eq("rst_mode", int'(mode), 0);
      check_eq("rst_pending", int'(switch_pending), 0);
      check_eq("rst_holdoff", int'(holdoff_active), 0);
      check_eq("rst_r", int'(r_port), 10);
      check_eq("rst_x", int'(x_coor), 100);
      check_eq("rst_toff", int'(target_off), 0);
      check_eq("rst_shoot", int'(shoot), 1);
      check_eq("rst_red", int'(red_detect), 1);

      // held next key: one step only
      kd = 8'h20;
      repeat (10) tick();
      check_eq("held_pending", int'(switch_pending), 1);
      check_eq("held_mode", int'(mode), 0);
      kd = 8'h00;
      tick();
      check_eq("prefs_mode", int'(mode), 0);
      frame();
      check_eq("c1_mode", int'(mode), 1);
      check_eq("c1_pending", int'(switch_pending), 0);
      check_eq("c1_r", int'(r_port), 11);
      check_eq("c1_g", int'(g_port), 2);
      check_eq("c1_b", int'(b_port), 5);
      check_eq("c1_x", int'(x_coor), 200);
      check_eq("c1_y", int'(y_coor), 20);
      check_eq("c1_toff", int'(target_off), 1);
      check_eq("c1_holdoff", int'(holdoff_active), HO);
      check_eq("c1_shoot", int'(shoot), 1 - HO);
      check_eq("c1_red", int'(red_detect), 1 - HO);
      frame();
      check_eq("ho1_active", int'(holdoff_active), HO);
      check_eq("ho1_shoot", int'(shoot), 1 - HO);
      frame();
      check_eq("ho2_active", int'(holdoff_active), 0);
      check_eq("ho2_shoot", int'(shoot), 1);
      check_eq("ho2_mode", int'(mode), 1);

      // back to 0, then prev wraps to 2, then next wraps to 0
      press(6);
      check_eq("p1_pending", int'(switch_pending), 1);
      frame();
      check_eq("p1_mode", int'(mode), 0);
      press(6);
      check_eq("p2_pending", int'(switch_pending), 1);
      check_eq("p2_mode_hold", int'(mode), 0);
      frame();
      check_eq("wrap_prev_mode", int'(mode), 2);
      check_eq("wrap_prev_g", int'(g_port), 3);
      check_eq("wrap_prev_y", int'(y_coor), 30);
      check_eq("wrap_prev_b", int'(b_port), 6);
      press(5);
      check_eq("n2_pending", int'(switch_pending), 1);
      frame();
      check_eq("wrap_next_mode", int'(mode), 0);
      check_eq("wrap_next_holdoff", int'(holdoff_active), HO);

      // simultaneous rising edges: no step
      kd = 8'h60;
      tick();
      check_eq("both_pending", int'(switch_pending), 0);
      kd = 8'h00;
      tick();
      frame();
      check_eq("both_mode", int'(mode), 0);
      frame();
      frame();
      check_eq("clr_holdoff", int'(holdoff_active), 0);

      // request cancelled by stepping back
      press(5);
      check_eq("cx_pending1", int'(switch_pending), 1);
      press(6);
      check_eq("cx_pending0", int'(switch_pending), 0);
      frame();
      check_eq("cx_mode", int'(mode), 0);
      check_eq("cx_holdoff", int'(holdoff_active), 0);

      // step coincident with frame_start
      press(5);
      kd = 8'h20;
      fs = 1'b1;
      tick();
      fs = 1'b0;
      kd = 8'h00;
      check_eq("co_mode", int'(mode), 1);
      check_eq("co_pending", int'(switch_pending), 1);
      check_eq("co_holdoff", int'(holdoff_active), HO);
      tick();
      frame();
      check_eq("co2_mode", int'(mode), 2);
      check_eq("co2_pending", int'(switch_pending), 0);

      // reset during pending request and holdoff
      press(5);
      check_eq("rr_pending", int'(switch_pending), 1);
      check_eq("rr_holdoff", int'(holdoff_active), HO);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("rr_mode", int'(mode), 0);
      check_eq("rr_pending0", int'(switch_pending), 0);
      check_eq("rr_holdoff0", int'(holdoff_active), 0);
      check_eq("rr_shoot", int'(shoot), 1);
      frame();
      check_eq("rr_frame_mode", int'(mode), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mode_sel_mux.md
MODE_SEL_MUX -- requirements
Module: mode_sel_mux

Interface
REQ-001 Parameter NUM_MODES, default 2, number of video/targeting sources selectable; legal range 2..8.
REQ-002 Parameter INIT_MODE, default 0, mode index loaded at reset; legal range 0..NUM_MODES-1.
REQ-003 Parameter KEY_NEXT_BIT, default 5, keyboard_data bit index that steps to the next mode.
REQ-004 Parameter KEY_PREV_BIT, default 6, keyboard_data bit index that steps to the previous mode.
REQ-005 Parameter HOLDOFF_FRAMES, default 2, frames during which shoot/red_detect are masked after a mode switch; legal range 1..15.
REQ-006 Port clk  input  1  system clock, all state on rising edge.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port keyboard_data  input  8  decoded keyboard level bits.
REQ-009 Port frame_start  input  1  one-cycle pulse at start of each VGA frame (vsync boundary).
REQ-010 Port target_off_in  input  NUM_MODES  per-mode target_off, bit i = mode i.
REQ-011 Port r_port_in, g_port_in, b_port_in  input  4*NUM_MODES each  per-mode colour, slice [4i+3:4i] = mode i.
REQ-012 Port x_coor_in, y_coor_in  input  10*NUM_MODES each  per-mode coordinates, slice [10i+9:10i] = mode i.
REQ-013 Port red_detect_in, shoot_in  input  NUM_MODES each  per-mode detect and fire flags.
REQ-014 Port target_off, red_detect, shoot  output  1 each  selected-mode flags.
REQ-015 Port r_port, g_port, b_port  output  4 each  selected-mode colour.
REQ-016 Port x_coor, y_coor  output  10 each  selected-mode coordinates.
REQ-017 Port mode  output  3  current active mode index, upper unused bits zero.
REQ-018 Port switch_pending  output  1  high while a requested mode change awaits frame_start.
REQ-019 Port holdoff_active  output  1  high while post-switch masking is in effect.

Function
REQ-020 Key steps SHALL be rising-edge detected using a one-cycle registered copy of each key bit; a held key yields exactly one step.
REQ-021 Next step: target = (target+1) wrap NUM_MODES-1 -> 0; prev step: target = (target-1) wrap 0 -> NUM_MODES-1.
REQ-022 Rising edges on next and prev in the same cycle SHALL be ignored (no step).
REQ-023 Steps SHALL modify a target register; switch_pending = (target != mode); steps accumulate relative to target, not mode.
REQ-024 mode SHALL load target only on the cycle frame_start=1; mode never changes mid-frame.
REQ-025 Step and frame_start in the same cycle: commit uses target before the step; the step updates target from that value, leaving switch_pending=1 if it now differs from new mode.
REQ-026 Stepping back to the current mode before frame_start SHALL cancel the request (switch_pending=0, no commit, no holdoff).
REQ-027 All data outputs SHALL be combinational selection of mode-indexed slices, zero-cycle latency from *_in.
REQ-028 A commit that changes mode SHALL load the holdoff counter with HOLDOFF_FRAMES; each later frame_start decrements it to 0; holdoff_active = (counter != 0).
REQ-029 Commit during active holdoff SHALL reload the counter to HOLDOFF_FRAMES.
REQ-030 While holdoff_active=1, shoot and red_detect SHALL be forced 0; other outputs unaffected.

Reset
REQ-031 On reset: mode=target=INIT_MODE, key edge registers=0, holdoff counter=0, switch_pending=0, holdoff_active=0.
REQ-032 Outputs after reset reflect mode INIT_MODE inputs unmasked; reset mid-request or mid-holdoff discards both.

Configuration
REQ-033 Macro MUX_SHOOT_HOLDOFF_EN defined: REQ-028..REQ-030 active.
REQ-034 Macro MUX_SHOOT_HOLDOFF_EN undefined: no holdoff counter, holdoff_active tied 0, shoot/red_detect never masked; all else identical.

Verification
REQ-035 NUM_MODES=3, reset, pulse bit5 high 10 cycles -> target=1, switch_pending=1, mode=0 until frame_start; at frame_start mode=1, outputs equal slice 1.
REQ-036 NUM_MODES=3, mode=0, one prev press -> target=2; frame_start -> mode=2 (wrap); then next press + frame_start -> mode=0.
REQ-037 bit5 and bit6 rise same cycle -> target unchanged, switch_pending=0.
REQ-038 next then prev before frame_start -> switch_pending=0; frame_start -> mode unchanged, holdoff_active=0.
REQ-039 With macro, HOLDOFF_FRAMES=2, shoot_in all 1: commit -> shoot=0 for 2 frame_start pulses, shoot=1 after second; without macro shoot=1 throughout.
REQ-040 Assert reset while switch_pending=1 and holdoff_active=1 -> next cycle mode=INIT_MODE, both flags 0.
